// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_SKIDDED = 2'd2
  } pipe_state_e;

  // Per-stage bundle widths
  localparam int unsigned IFID_DATA_W = 64;   // Instruction, pc
  localparam int unsigned IFID_CTRL_W = 14;
  localparam int unsigned IDEX_DATA_W = 192;  // Instruction, pc, BranchTarget, Op1, Op2, Immx
  localparam int unsigned IDEX_CTRL_W = 14;
  localparam int unsigned EXMA_DATA_W = 160;  // Instruction, pc, BranchTarget, Op2, AluResult1
  localparam int unsigned EXMA_CTRL_W = 14;
  localparam int unsigned MARW_DATA_W = 128;  // Instruction, pc, LdResult, AluResult
  localparam int unsigned MARW_CTRL_W = 14;

  // EX/MA control bit positions; an all-zero control word is a NOP
  localparam int unsigned IS_ST       = 0;
  localparam int unsigned IS_LD       = 1;
  localparam int unsigned IS_WB       = 2;
  localparam int unsigned IS_IMM      = 3;
  localparam int unsigned IS_BEQ      = 4;
  localparam int unsigned IS_BGT      = 5;
  localparam int unsigned IS_UBRANCH  = 6;
  localparam int unsigned IS_RET      = 7;
  localparam int unsigned IS_CALL     = 8;
  localparam int unsigned ALU_SIG_LSB = 9;
  localparam int unsigned ALU_SIG_MSB = 13;

  localparam logic [EXMA_CTRL_W-1:0] CTRL_NOP = '0;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_current;
    logic [31:0] branch_target;
    logic [31:0] op2;
    logic [31:0] alu_result1;
  } exma_data_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One data+control bundle register with load and synchronous clear; clear wins.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = EXMA_DATA_W,
  parameter int unsigned CTRL_W = EXMA_CTRL_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_data <= '0;
      q_ctrl <= '0;
    end else if (clear) begin
      q_data <= '0;
      q_ctrl <= '0;
    end else if (load) begin
      q_data <= d_data;
      q_ctrl <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional skid entry, flush to NOP
// and a saturating stall-cycle counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = EXMA_DATA_W,
  parameter int unsigned CTRL_W  = EXMA_CTRL_W,
  parameter bit          SKID    = 1'b1,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  input  logic               flush,
  output logic [STALL_W-1:0] stall_cnt
);

  pipe_state_e       state, state_nxt;
  logic              in_fire, out_fire;
  logic              main_load, main_clr, main_from_skid;
  logic              skid_load, skid_clr;
  logic [DATA_W-1:0] main_d_data, skid_data;
  logic [CTRL_W-1:0] main_d_ctrl, skid_ctrl;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != ST_EMPTY);
    end
  end

  // Next state and entry control; flush overrides every transfer
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_nxt = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            // Only reachable with a skid entry; without one in_ready blocks it
            if (SKID) begin
              state_nxt = ST_SKIDDED;
              skid_load = 1'b1;
            end
          end else if (out_fire) begin
            state_nxt = ST_EMPTY;
            main_clr  = 1'b1;
          end
        end
        ST_SKIDDED: begin
          if (out_fire) begin
            state_nxt      = ST_FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign main_d_data = main_from_skid ? skid_data : in_data;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  // Main entry drives the outputs; it is cleared whenever it empties
  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (main_load),
    .clear  (main_clr),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .q_data (out_data),
    .q_ctrl (out_ctrl)
  );

  if (SKID) begin : g_skid
    logic in_ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) in_ready_q <= 1'b1;
      else          in_ready_q <= (state_nxt != ST_SKIDDED);
    end

    assign in_ready = in_ready_q;

    pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (skid_load),
      .clear  (skid_clr),
      .d_data (in_data),
      .d_ctrl (in_ctrl),
      .q_data (skid_data),
      .q_ctrl (skid_ctrl)
    );
  end else begin : g_noskid
    logic unused_skid_ctl;

    assign in_ready        = out_ready | ~out_valid;
    assign skid_data       = '0;
    assign skid_ctrl       = '0;
    assign unused_skid_ctl = skid_load ^ skid_clr;
  end

  // Saturating count of cycles with a held bundle that downstream refuses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: one skid-mode stage (4-bit stall counter) and one
// single-register stage driven with the same stimulus.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned DW = EXMA_DATA_W;
  localparam int unsigned CW = EXMA_CTRL_W;
  localparam int unsigned BW = DW + CW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, out_ready, flush;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          ir [2];
  logic          ov [2];
  logic [DW-1:0] od [2];
  logic [CW-1:0] oc [2];
  logic [3:0]    sc_s;
  logic [15:0]   sc_r;

  // Reference model: each stage is an ordered queue of accepted bundles
  logic [BW-1:0] exp_q [2][$];
  logic          mdl_rdy [2];
  int            stall_m [2];
  bit            chk_en;
  int            total = 0;
  int            bad   = 0;

  logic          m_ev, m_er;
  logic [BW-1:0] m_eb;
  int            m_as;
  int            m_max;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .STALL_W(4)) u_skid (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_ctrl(oc[0]), .flush(flush), .stall_cnt(sc_s)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .STALL_W(16)) u_reg (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_ctrl(oc[1]), .flush(flush), .stall_cnt(sc_r)
  );

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_out_valid[%0d]", i), 192'(ov[i]), 192'(0));
      chk($sformatf("rst_in_ready[%0d]", i), 192'(ir[i]), 192'(1));
      chk($sformatf("rst_bundle[%0d]", i), 192'({oc[i], od[i]}), 192'(0));
    end
    chk("rst_stall[0]", 192'(sc_s), 192'(0));
    chk("rst_stall[1]", 192'(sc_r), 192'(0));
  endtask

  // Monitor: compare the presented output against the queue head, pop on out_fire
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        m_ev  = (exp_q[i].size() != 0);
        m_eb  = m_ev ? exp_q[i][0] : '0;
        m_er  = (i == 0) ? (exp_q[i].size() < 2) : (!m_ev || out_ready);
        m_as  = (i == 0) ? 32'(sc_s) : 32'(sc_r);
        m_max = (i == 0) ? 15 : 65535;
        chk($sformatf("out_valid[%0d]", i), 192'(ov[i]), 192'(m_ev));
        chk($sformatf("in_ready[%0d]", i), 192'(ir[i]), 192'(m_er));
        chk($sformatf("bundle[%0d]", i), 192'({oc[i], od[i]}), 192'(m_eb));
        chk($sformatf("stall_cnt[%0d]", i), 192'(m_as), 192'(stall_m[i]));
        mdl_rdy[i] = m_er;
        if (m_ev && out_ready) void'(exp_q[i].pop_front());
        if (m_ev && !out_ready && stall_m[i] < m_max) stall_m[i]++;
      end
    end
  end

  // One cycle of stimulus; accepted bundles enter the scoreboard, flush kills all
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (fl) exp_q[i].delete();
      else if (iv && mdl_rdy[i]) exp_q[i].push_back({c, d});
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, ordy, 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      stall_m[i] = 0;
      mdl_rdy[i] = 1'b1;
    end
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; flush = 1'b0; reset_n = 1'b0; chk_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_state();
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk_en = 1'b1;

    // Streaming at full throughput
    for (int k = 1; k <= 8; k++) step(1'b1, DW'(k), CW'(k), 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Back-pressure into the skid entry, then drain in order
    step(1'b1, DW'(32'hA), CW'(14'h041), 1'b0, 1'b0);
    step(1'b1, DW'(32'hB), CW'(14'h082), 1'b0, 1'b0);
    idle(1'b0);
    repeat (3) idle(1'b1);

    // Flush while skidded with a live all-ones control word arriving
    step(1'b1, DW'(32'h11), CW'(14'h005), 1'b0, 1'b0);
    step(1'b1, DW'(32'h12), CW'(14'h006), 1'b0, 1'b0);
    step(1'b1, DW'(32'h13), CW'(14'h3FFF), 1'b0, 1'b1);
    repeat (2) idle(1'b1);

    // Stall counter saturation on the 4-bit instance
    step(1'b1, DW'(32'h21), CW'(14'h004), 1'b0, 1'b0);
    repeat (20) idle(1'b0);
    chk("stall_saturated", 192'(sc_s), 192'(15));
    idle(1'b1);

    // Asynchronous reset while the skid instance is skidded
    step(1'b1, DW'(32'h31), CW'(14'h001), 1'b0, 1'b0);
    step(1'b1, DW'(32'h32), CW'(14'h002), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_reset_skidded_in_ready", 192'(ir[0]), 192'(0));
    #1;
    chk_en   = 1'b0;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1 chk_reset_state();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk_en = 1'b1;
    step(1'b1, DW'(32'h41), CW'(14'h044), 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Randomized traffic with occasional flushes
    repeat (500) begin
      step($urandom_range(0, 3) != 0,
           DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}),
           CW'($urandom()),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0);
    end
    repeat (3) idle(1'b1);
    chk("drained[0]", 192'(exp_q[0].size()), 192'(0));
    chk("drained[1]", 192'(exp_q[1].size()), 192'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
